comp_serial_nb: RTL and testbench
=================================

COMP_SERIAL_NB -- requirements
Module: comp_serial_nb

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1; 1 enables two's-complement compare via signed_mode, 0 forces unsigned compare.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 signed_mode  input  1  1 = signed compare, 0 = unsigned; sampled with start; ignored when SIGNED_EN=0.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while a compare is in progress.
REQ-010 done  output  1  one-cycle pulse when result is updated.
REQ-011 result  output  2  11 = A==B, 10 = A>B, 01 = A<B, 00 = no result since reset.
REQ-012 bit_cnt  output  clog2(WIDTH+1)  number of bit positions examined by the last completed compare.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-014 In IDLE with start=1 at a rising edge: latch a, b and effective mode (signed_mode AND SIGNED_EN); set idx=WIDTH-1; go to SCAN; busy=1 from that edge.
REQ-015 In IDLE with start=0 the state, result and bit_cnt SHALL hold.
REQ-016 In SCAN, each rising edge SHALL evaluate exactly one bit pair a[idx], b[idx], MSB first.
REQ-017 Differing bits, unsigned mode, or idx<WIDTH-1: a[idx]=1 gives result 10, otherwise 01.
REQ-018 Differing bits, signed mode, at idx=WIDTH-1 (sign bit): a[idx]=1 gives result 01, otherwise 10.
REQ-019 On differing bits the compare SHALL terminate at that edge: result updated, bit_cnt=WIDTH-idx, done=1 for the following cycle, busy=0, state to IDLE.
REQ-020 Equal bits with idx>0: decrement idx and remain in SCAN.
REQ-021 Equal bits with idx=0: result 11, bit_cnt=WIDTH, done pulse, state to IDLE.
REQ-022 Latency: for first differing bit at position k, done SHALL be high in cycle WIDTH-k+1 after the start edge; equal operands take WIDTH+1 cycles.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing; a, b and signed_mode changes during SCAN SHALL not affect the compare in flight.
REQ-024 start may be asserted in the same cycle done is high (state is IDLE); it SHALL be accepted, giving back-to-back compares with one idle cycle minimum.
REQ-025 result and bit_cnt SHALL hold their values from done until the next compare terminates; they SHALL not change during SCAN.
REQ-026 done SHALL never be high for more than one consecutive cycle.
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, busy=0, done=0, result=00, bit_cnt=0, idx=WIDTH-1, and clear the latched operands.
REQ-029 Reset asserted mid-SCAN SHALL abort the compare with no done pulse; after release the block SHALL accept start on the first rising edge with rst_n=1.

Verification
REQ-030 WIDTH=8, unsigned, a=0xA5, b=0x25 -> result=10, bit_cnt=1, done in cycle 2 after start.
REQ-031 WIDTH=8, unsigned, a=0x3C, b=0x3C -> result=11, bit_cnt=8, done in cycle 9; busy high for exactly 8 cycles.
REQ-032 WIDTH=8, signed_mode=1, a=0x80 (-128), b=0x01 -> result=01, bit_cnt=1; same operands unsigned -> result=10.
REQ-033 WIDTH=8, unsigned, a=0x12, b=0x13 -> result=01, bit_cnt=8; a second start pulse at cycle 3 is ignored and produces exactly one done.
REQ-034 Assert rst_n=0 at cycle 4 of an equal-operand compare -> outputs zero asynchronously, no done; a new compare a=0x01, b=0x00 after release -> result=10, bit_cnt=8.
REQ-035 Random regression at WIDTH=4, 8 and 16, SIGNED_EN=0 and 1, ~10k compares; result and bit_cnt SHALL match a reference model, including back-to-back starts.

Source files
------------

// File: rtl/comp_serial_nb.sv
// comp_serial_nb: bit-serial magnitude comparator, MSB first.
// A compare is started by a start pulse in IDLE. It examines one bit pair per
// clock and stops at the first differing bit, or after the LSB when the
// operands are equal. All outputs are registered.
//
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - asynchronous active-low reset
//   start       - request pulse, sampled only in IDLE
//   signed_mode - 1 = two's-complement compare (only when SIGNED_EN != 0)
//   a, b        - operands, latched with start
//   busy        - compare in progress
//   done        - one-cycle pulse when result/bit_cnt are updated
//   result      - 11 A==B, 10 A>B, 01 A<B, 00 nothing since reset
//   bit_cnt     - bit positions examined by the last completed compare
//
// state | meaning
// IDLE  | waiting for start; result/bit_cnt hold
// SCAN  | comparing a_q[idx] against b_q[idx], idx counting down
module comp_serial_nb #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 result,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ALL = CW'(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic            mode_q;
  logic [IW-1:0]   idx;
  logic            bit_a, bit_b;
  logic            finish;
  logic [1:0]      res_nx;
  logic [CW-1:0]   cnt_nx;

  assign bit_a = a_q[idx];
  assign bit_b = b_q[idx];

  always_comb begin
    state_nx = state;
    res_nx   = result;
    cnt_nx   = bit_cnt;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SCAN;
      end
      SCAN: begin
        if (bit_a != bit_b) begin
          finish   = 1'b1;
          state_nx = IDLE;
          // In signed mode a set sign bit means the more negative operand.
          if (mode_q && (idx == IDX_TOP)) res_nx = bit_a ? 2'b01 : 2'b10;
          else                            res_nx = bit_a ? 2'b10 : 2'b01;
          cnt_nx = CNT_ALL - CW'(idx);
        end else if (idx == '0) begin
          finish   = 1'b1;
          state_nx = IDLE;
          res_nx   = 2'b11;
          cnt_nx   = CNT_ALL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      idx     <= IDX_TOP;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 2'b00;
      bit_cnt <= '0;
    end else begin
      done    <= finish;
      result  <= res_nx;
      bit_cnt <= cnt_nx;
      if (state == IDLE) begin
        if (start) begin
          a_q    <= a;
          b_q    <= b;
          mode_q <= signed_mode && (SIGNED_EN != 0);
          idx    <= IDX_TOP;
          busy   <= 1'b1;
        end
      end else begin
        if (finish) begin
          busy <= 1'b0;
          idx  <= IDX_TOP;
        end else begin
          idx <= idx - IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_comp_serial_nb.sv
module tb_comp_serial_nb;

  typedef struct {
    logic [1:0] res;
    int         cnt;
    int         cyc;
  } exp_t;

  localparam int NCYC = 12000;

  logic clk = 1'b0;
  logic rst_n, rst_d_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   fin [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Directed-test instance, WIDTH=8, SIGNED_EN=1
  logic       d_st, d_sm, d_busy, d_done;
  logic [7:0] d_a, d_b;
  logic [1:0] d_res;
  logic [3:0] d_bc;
  exp_t       qd[$];

  comp_serial_nb #(.WIDTH(8), .SIGNED_EN(1)) dut_d (
    .clk(clk), .rst_n(rst_d_n), .start(d_st), .signed_mode(d_sm),
    .a(d_a), .b(d_b), .busy(d_busy), .done(d_done),
    .result(d_res), .bit_cnt(d_bc)
  );

  always @(negedge clk) begin
    if (d_done) begin
      if (qd.size() == 0) chk("dir_spurious_done", 1, 0);
      else begin
        exp_t x;
        x = qd.pop_front();
        chk("dir_result", int'(d_res), int'(x.res));
        chk("dir_bit_cnt", int'(d_bc), x.cnt);
        chk("dir_latency", cyc, x.cyc);
      end
    end
  end

  // Called at a negedge; start is sampled at the next rising edge.
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                         input logic [1:0] er, input int ec, input int extra);
    int  e, nb;
    bit  idle;
    d_a = av; d_b = bv; d_sm = sm; d_st = 1'b1;
    e = cyc + 1;
    qd.push_back('{er, ec, e + ec});
    nb = 0;
    idle = 1'b0;
    for (int i = 1; i <= 100 && !idle; i++) begin
      @(negedge clk);
      d_st = (i == extra);
      d_a  = 8'($urandom);
      d_b  = 8'($urandom);
      d_sm = 1'($urandom);
      if (!d_busy) idle = 1'b1;
      else nb++;
    end
    d_st = 1'b0;
    chk("dir_busy_cycles", nb, ec);
  endtask

  // Random-regression instances
  for (genvar g = 0; g < 5; g++) begin : g_rand
    localparam int W  = (g == 0) ? 4 : (g < 3) ? 8 : 16;
    localparam int SE = (g == 1 || g == 3) ? 0 : 1;

    logic                   st, sm, busy, done;
    logic [W-1:0]           a, b;
    logic [1:0]             res;
    logic [$clog2(W+1)-1:0] bc;
    exp_t                   q[$];

    comp_serial_nb #(.WIDTH(W), .SIGNED_EN(SE)) dut (
      .clk(clk), .rst_n(rst_n), .start(st), .signed_mode(sm),
      .a(a), .b(b), .busy(busy), .done(done),
      .result(res), .bit_cnt(bc)
    );

    always @(negedge clk) begin
      if (done) begin
        if (q.size() == 0) chk($sformatf("w%0d_s%0d_spurious_done", W, SE), 1, 0);
        else begin
          exp_t x;
          x = q.pop_front();
          chk($sformatf("w%0d_s%0d_result", W, SE), int'(res), int'(x.res));
          chk($sformatf("w%0d_s%0d_bit_cnt", W, SE), int'(bc), x.cnt);
          chk($sformatf("w%0d_s%0d_latency", W, SE), cyc, x.cyc);
        end
      end
    end

    initial begin
      int         free_at, e, n, ia, ib;
      bit         md, fnd;
      logic [1:0] er;
      st = 1'b0; sm = 1'b0; a = '0; b = '0;
      free_at = 0;
      wait (rst_n === 1'b1);
      for (int c = 0; c < NCYC; c++) begin
        st = ($urandom_range(0, 7) != 0);
        a  = W'($urandom);
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
          default: b = W'($urandom);
        endcase
        sm = 1'($urandom);
        e  = cyc + 1;
        if (st && e >= free_at) begin
          md = sm && (SE != 0);
          if (md) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
          end else begin
            ia = int'(a);
            ib = int'(b);
          end
          er = (ia > ib) ? 2'b10 : (ia < ib) ? 2'b01 : 2'b11;
          n = W;
          fnd = 1'b0;
          for (int i = W - 1; i >= 0; i--) begin
            if (!fnd && a[i] != b[i]) begin
              n = W - i;
              fnd = 1'b1;
            end
          end
          q.push_back('{er, n, e + n});
          free_at = e + n + 1;
        end
        @(negedge clk);
      end
      st = 1'b0;
      repeat (W + 4) @(negedge clk);
      chk($sformatf("w%0d_s%0d_queue_drained", W, SE), q.size(), 0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    bit all;
    rst_n = 1'b0; rst_d_n = 1'b0;
    d_st = 1'b0; d_sm = 1'b0; d_a = '0; d_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", int'(d_res), 0);
    chk("reset_bit_cnt", int'(d_bc), 0);
    chk("reset_busy", int'(d_busy), 0);
    chk("reset_done", int'(d_done), 0);
    rst_n = 1'b1; rst_d_n = 1'b1;

    run_cmp(8'hA5, 8'h25, 1'b0, 2'b10, 1, 0);
    run_cmp(8'h3C, 8'h3C, 1'b0, 2'b11, 8, 0);
    run_cmp(8'h80, 8'h01, 1'b1, 2'b01, 1, 0);
    run_cmp(8'h80, 8'h01, 1'b0, 2'b10, 1, 0);
    run_cmp(8'hFF, 8'hFE, 1'b1, 2'b10, 8, 0);
    run_cmp(8'h12, 8'h13, 1'b0, 2'b01, 8, 3);

    // Abort an equal-operand compare at cycle 4 with an asynchronous reset.
    d_a = 8'h3C; d_b = 8'h3C; d_sm = 1'b0; d_st = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      d_st = 1'b0;
    end
    chk("abort_busy_before", int'(d_busy), 1);
    #2 rst_d_n = 1'b0;
    #1;
    chk("abort_result", int'(d_res), 0);
    chk("abort_bit_cnt", int'(d_bc), 0);
    chk("abort_busy", int'(d_busy), 0);
    chk("abort_done", int'(d_done), 0);
    repeat (2) @(negedge clk);
    rst_d_n = 1'b1;
    run_cmp(8'h01, 8'h00, 1'b0, 2'b10, 8, 0);
    repeat (3) @(negedge clk);
    chk("dir_queue_drained", qd.size(), 0);

    all = 1'b0;
    for (int i = 0; i < 20000 && !all; i++) begin
      @(negedge clk);
      all = fin[0] && fin[1] && fin[2] && fin[3] && fin[4];
    end
    chk("random_finished", int'(all), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
